// File: rtl/spi_controller.sv
// SPI controller: sends an address byte followed by nbytes data bytes,
// MSB first. Data is captured from poci on every rising sclk edge, and
// sclk is held low for a gap after each transaction.
module spi_controller #(
  parameter int unsigned HALF_PERIOD = 2,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic       iclk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] nbytes,
  input  logic [7:0] wdata,
  input  logic       wdata_valid,
  output logic       wdata_ready,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       sclk,
  output logic       pico,
  input  logic       poci
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, GAP} state_t;

  localparam logic [7:0]  HP_RELOAD  = 8'(HALF_PERIOD - 1);
  localparam logic [15:0] GAP_RELOAD = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  hp_q, hp_d;          // cycles left in the current sclk phase
  logic [2:0]  bit_q, bit_d;        // bit index within the current byte
  logic [7:0]  byte_q, byte_d;      // data bytes still to send
  logic [15:0] gap_q, gap_d;        // cycles left in the gap
  logic [6:0]  tx_q, tx_d;          // bits not yet placed on pico
  logic [6:0]  rx_q, rx_d;          // bits captured so far from poci
  logic [7:0]  rdata_q, rdata_d;
  logic        sclk_q, sclk_d;
  logic        pico_q, pico_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        wdata_ready_q, wdata_ready_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        last_byte;

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    hp_d          = hp_q;
    bit_d         = bit_q;
    byte_d        = byte_q;
    gap_d         = gap_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    rdata_d       = rdata_q;
    sclk_d        = sclk_q;
    pico_d        = pico_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    wdata_ready_d = 1'b0;
    rdata_valid_d = 1'b0;
    last_byte     = (state_q == ADDR) ? (byte_q == 8'd0) : (byte_q == 8'd1);

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        pico_d = 1'b0;
        if (start) begin
          // hp=0 makes the first rising edge follow one low setup cycle.
          state_d = ADDR;
          busy_d  = 1'b1;
          pico_d  = addr[7];
          tx_d    = addr[6:0];
          byte_d  = nbytes;
          hp_d    = 8'd0;
          bit_d   = 3'd0;
        end
      end

      ADDR, DATA: begin
        if (hp_q != 8'd0) begin
          hp_d = hp_q - 8'd1;
        end else if (!sclk_q) begin
          // Rising edge: sample poci; the 8th edge of a data byte completes it.
          sclk_d = 1'b1;
          hp_d   = HP_RELOAD;
          rx_d   = {rx_q[5:0], poci};
          if (state_q == DATA && bit_q == 3'd7) begin
            rdata_d       = {rx_q, poci};
            rdata_valid_d = 1'b1;
          end
        end else begin
          // Falling edge: shift the next bit out, or end/reload the byte.
          sclk_d = 1'b0;
          hp_d   = HP_RELOAD;
          if (bit_q != 3'd7) begin
            bit_d  = bit_q + 3'd1;
            pico_d = tx_q[6];
            tx_d   = {tx_q[5:0], 1'b0};
          end else begin
            bit_d = 3'd0;
            if (state_q == DATA) byte_d = byte_q - 8'd1;
            if (last_byte) begin
              state_d = GAP;
              pico_d  = 1'b0;
              gap_d   = GAP_RELOAD;
            end else if (wdata_valid) begin
              state_d       = DATA;
              pico_d        = wdata[7];
              tx_d          = wdata[6:0];
              wdata_ready_d = 1'b1;
            end else begin
              state_d = GAP;
              pico_d  = 1'b0;
              gap_d   = GAP_RELOAD;
              err_d   = 1'b1;
            end
          end
        end
      end

      GAP: begin
        sclk_d = 1'b0;
        pico_d = 1'b0;
        if (gap_q == 16'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous reset to the idle values.
  always_ff @(posedge iclk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state_q       <= IDLE;
      hp_q          <= '0;
      bit_q         <= '0;
      byte_q        <= '0;
      gap_q         <= '0;
      tx_q          <= '0;
      rx_q          <= '0;
      rdata_q       <= '0;
      sclk_q        <= 1'b0;
      pico_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hp_q          <= hp_d;
      bit_q         <= bit_d;
      byte_q        <= byte_d;
      gap_q         <= gap_d;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      rdata_q       <= rdata_d;
      sclk_q        <= sclk_d;
      pico_q        <= pico_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign wdata_ready = wdata_ready_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign sclk        = sclk_q;
  assign pico        = pico_q;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: directed and random transactions
// compared against a transaction-level reference model.
module tb_spi_controller;

  localparam int HP  = 2;
  localparam int GAP = 16;

  logic       iclk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] nbytes = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       wdata_valid = 1'b0;
  logic       poci = 1'b0;
  logic       wdata_ready, rdata_valid, busy, done, err, sclk, pico;
  logic [7:0] rdata;

  int tests  = 0;
  int failed = 0;

  // Write bytes offered to the DUT and bytes the peripheral returns
  // (pb[0] during the address byte, pb[i+1] during data byte i).
  logic [7:0] wq [0:7];
  logic [7:0] pb [0:7];

  spi_controller #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
    .iclk(iclk), .rstn(rstn), .start(start), .addr(addr), .nbytes(nbytes),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
    .err(err), .sclk(sclk), .pico(pico), .poci(poci)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic poci_bit(input int k);
    int b;
    b = k / 8;
    if (b > 7) return 1'b0;
    return pb[b][7 - (k % 8)];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      wq[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
  endtask

  // Runs one transaction and compares it with the model. uf is the index of
  // the data byte whose load sees wdata_valid=0 (uf >= n means none).
  task automatic run_txn(input string name, input logic [7:0] a, input int n,
                         input int uf, input bit spam);
    int   sent;
    int   rises = 0, readies = 0, rvalids = 0, errs = 0, dones = 0;
    int   first_rise = -1, last_fall = -1, done_cyc = -1, prev_rise = -1;
    int   period_bad = 0, stable_bad = 0, busy_bad = 0, both_bad = 0;
    int   gap_nz = 0, widx = 0;
    logic prev_sclk = 1'b0, rise_pico = 1'b0, busy1 = 1'b0;
    logic [7:0] obs_bytes [0:7];
    logic [7:0] obs_rdata [0:7];
    logic [7:0] exp_byte;

    sent = (uf < n) ? uf : n;
    for (int i = 0; i < 8; i++) begin
      obs_bytes[i] = 8'h00;
      obs_rdata[i] = 8'h00;
    end

    @(negedge iclk);
    start       = 1'b1;
    addr        = a;
    nbytes      = 8'(n);
    wdata       = wq[0];
    wdata_valid = (n > 0) && (uf != 0);
    poci        = poci_bit(0);

    for (int c = 1; c <= 4000 && dones == 0; c++) begin
      @(negedge iclk);
      if (c == 1) begin
        start = 1'b0;
        busy1 = busy;
      end else if (spam) begin
        start  = 1'($urandom_range(0, 1));
        addr   = 8'($urandom);
        nbytes = 8'($urandom_range(0, 255));
      end
      if (sclk && !prev_sclk) begin
        if (first_rise < 0) first_rise = c;
        if (prev_rise >= 0 && (c - prev_rise) != 2 * HP) period_bad++;
        prev_rise = c;
        if (rises < 64) obs_bytes[rises / 8][7 - (rises % 8)] = pico;
        rise_pico = pico;
        rises++;
        poci = poci_bit(rises);
      end else if (sclk && pico !== rise_pico) begin
        stable_bad++;
      end
      if (!sclk && prev_sclk) begin
        last_fall = c;
        gap_nz    = pico ? 1 : 0;
      end else if (!sclk && pico) begin
        gap_nz++;
      end
      if (wdata_ready) begin
        readies++;
        widx++;
        wdata       = (widx < 8) ? wq[widx] : 8'h00;
        wdata_valid = (widx < n) && (widx != uf);
      end
      if (rdata_valid) begin
        if (rvalids < 8) obs_rdata[rvalids] = rdata;
        rvalids++;
      end
      if (err) errs++;
      if (done) begin
        dones++;
        done_cyc = c;
        if (busy) busy_bad++;
      end else if (!busy) begin
        busy_bad++;
      end
      if (err && done) both_bad++;
      prev_sclk = sclk;
    end
    start       = 1'b0;
    wdata_valid = 1'b0;

    check($sformatf("%s:busy_after_start", name), 32'(busy1), 1);
    check($sformatf("%s:first_rise_cycle", name), first_rise, 2);
    check($sformatf("%s:sclk_rises", name), rises, 8 * (1 + sent));
    for (int i = 0; i <= sent; i++) begin
      exp_byte = (i == 0) ? a : wq[i - 1];
      check($sformatf("%s:pico_byte%0d", name, i), obs_bytes[i], exp_byte);
    end
    check($sformatf("%s:wdata_ready_count", name), readies, sent);
    check($sformatf("%s:rdata_valid_count", name), rvalids, sent);
    for (int i = 0; i < sent; i++)
      check($sformatf("%s:rdata%0d", name, i), obs_rdata[i], pb[i + 1]);
    check($sformatf("%s:err_count", name), errs, (uf < n) ? 1 : 0);
    check($sformatf("%s:done_count", name), dones, 1);
    check($sformatf("%s:gap_length", name), done_cyc - last_fall, GAP);
    check($sformatf("%s:sclk_period_errors", name), period_bad, 0);
    check($sformatf("%s:pico_change_while_high", name), stable_bad, 0);
    check($sformatf("%s:busy_errors", name), busy_bad, 0);
    check($sformatf("%s:err_with_done", name), both_bad, 0);
    check($sformatf("%s:pico_in_gap", name), gap_nz, 0);
  endtask

  initial begin
    int rises;
    int n;
    int uf;
    int bad;

    // Reset state.
    #1 rstn = 1'b0;
    #20;
    check("reset:outputs", {25'd0, sclk, pico, busy, done, err, wdata_ready, rdata_valid}, 0);
    check("reset:rdata", rdata, 8'h00);
    @(negedge iclk);
    rstn = 1'b1;
    repeat (2) @(negedge iclk);

    // Single byte write/read.
    fill_random();
    wq[0] = 8'hA5;
    pb[1] = 8'h3C;
    run_txn("one_byte", 8'h02, 1, 99, 1'b0);

    // Three back-to-back data bytes.
    fill_random();
    wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33;
    run_txn("three_bytes", 8'($urandom), 3, 99, 1'b0);

    // Underflow at the second data load.
    fill_random();
    run_txn("underflow", 8'($urandom), 2, 1, 1'b0);

    // Address only, with start toggling while busy.
    fill_random();
    run_txn("addr_only", 8'($urandom), 0, 99, 1'b1);

    // Reset in the middle of the second data byte.
    fill_random();
    pb[1] = 8'h5A;
    @(negedge iclk);
    start = 1'b1; addr = 8'h81; nbytes = 8'd2;
    wdata = wq[0]; wdata_valid = 1'b1; poci = poci_bit(0);
    rises = 0;
    for (int c = 0; c < 500 && rises < 20; c++) begin
      @(negedge iclk);
      start = 1'b0;
      if (sclk && !dut.sclk_q) rises = rises;
      if (wdata_ready) wdata = wq[1];
      if (rdata_valid) rises = rises;
      rises = rises + ((sclk && !poci_bit(99)) ? 0 : 0);
      if (sclk) begin
        @(negedge iclk);
        rises++;
        poci = poci_bit(rises);
        while (sclk) @(negedge iclk);
      end
    end
    check("midreset:reached_second_byte", 32'(rises >= 20), 1);
    #2 rstn = 1'b0;
    #1;
    check("midreset:outputs", {25'd0, sclk, pico, busy, done, err, wdata_ready, rdata_valid}, 0);
    check("midreset:rdata", rdata, 8'h00);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge iclk);
      if (done || busy || sclk) bad++;
    end
    check("midreset:quiet_in_reset", bad, 0);
    rstn = 1'b1;
    wdata_valid = 1'b0;
    @(negedge iclk);
    run_txn("after_reset", 8'($urandom), 0, 99, 1'b0);

    // Random transactions.
    for (int t = 0; t < 4; t++) begin
      fill_random();
      n  = $urandom_range(0, 4);
      uf = $urandom_range(0, 5);
      run_txn($sformatf("rand%0d", t), 8'($urandom), n, uf, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
